mem_watch: RTL

- Parametrised memory-tap observer for CPU simulation and debug.
- Watches NUM_WORDS memory words of WIDTH bits, presented as one flattened bus, and detects every word whose value changes.
- Emits a change event (index, value, timestamp) on a valid/ready stream through an internal FIFO.
- Counts coalesced changes and flags program quiescence, so benches stop when execution settles rather than after a fixed cycle count.

---
 rtl/mem_watch_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/mem_watch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_watch_pkg.sv
// Shared sizing helpers and event record layout for mem_watch and future
// trace blocks that pack {index, data, time} records.
package mem_watch_pkg;

  // Index width for a bank of num_words words; never narrower than 1 bit.
  function automatic int calc_idx_w(input int num_words);
    int w;
    w = $clog2(num_words);
    return (w < 1) ? 1 : w;
  endfunction

  // Total width of one packed event record.
  function automatic int calc_ev_w(input int num_words, input int width, input int ts_w);
    return calc_idx_w(num_words) + width + ts_w;
  endfunction

  // Record layout, LSB first: time, then data, then index.
  localparam int EV_TIME_LSB = 0;

  function automatic int ev_data_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int ev_index_lsb(input int width, input int ts_w);
    return width + ts_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is presented on dout whenever
// empty is low; dout reads zero while empty. A push is accepted when full
// only if a pop happens at the same edge.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards all stored entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mem_watch.sv
// Memory-tap observer: keeps a shadow copy of NUM_WORDS words, marks words
// that change as pending, and a lowest-index-first scanner turns pending
// words into {index, value, timestamp} events queued in a FIFO. Repeated
// changes of a still-pending word are coalesced and counted in drop_count.
// idle_done is a sticky flag raised after IDLE_LIMIT fully quiet edges.
//
// Event stream handshake: ev_valid high means ev_index/ev_data/ev_time hold
// the oldest event and stay stable until a rising edge sees
// ev_valid && ev_ready, which consumes it; ev_valid never depends on ev_ready.
module mem_watch
  import mem_watch_pkg::*;
#(
  parameter int NUM_WORDS  = 19,
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 8,
  parameter int TS_W       = 32,
  parameter int IDLE_LIMIT = 1000,
  localparam int IDX_W     = calc_idx_w(NUM_WORDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_WORDS*WIDTH-1:0] mem_flat,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [IDX_W-1:0]           ev_index,
  output logic [WIDTH-1:0]           ev_data,
  output logic [TS_W-1:0]            ev_time,
  output logic [15:0]                drop_count,
  output logic                       idle_done
);

  localparam int EV_W         = calc_ev_w(NUM_WORDS, WIDTH, TS_W);
  localparam int EV_DATA_LSB  = ev_data_lsb(TS_W);
  localparam int EV_INDEX_LSB = ev_index_lsb(WIDTH, TS_W);
  localparam int Q_W          = $clog2(IDLE_LIMIT + 1);

  logic [NUM_WORDS*WIDTH-1:0] shadow;
  logic [NUM_WORDS-1:0]       pending;
  logic [NUM_WORDS-1:0]       changed;
  logic [NUM_WORDS-1:0]       clear_mask;
  logic                       primed;
  logic [TS_W-1:0]            cycle_cnt;
  logic [15:0]                drop_q;
  logic [31:0]                drop_inc;
  logic [31:0]                drop_sum;
  logic [Q_W-1:0]             quiet_cnt;
  logic                       idle_q;
  logic                       quiet_edge;
  int                         scan_int;
  logic [IDX_W-1:0]           scan_idx;
  logic [WIDTH-1:0]           scan_word;
  logic                       scan_push;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [EV_W-1:0]            push_rec;
  logic [EV_W-1:0]            head_rec;

  // Per-word change detection against the shadow, only once baselined.
  always_comb begin
    changed = '0;
    if (en && primed) begin
      for (int i = 0; i < NUM_WORDS; i++)
        changed[i] = (mem_flat[i*WIDTH +: WIDTH] != shadow[i*WIDTH +: WIDTH]);
    end
  end

  // Scanner: pick the lowest pending word and push it if the FIFO has room.
  always_comb begin
    scan_int   = 0;
    clear_mask = '0;
    for (int i = NUM_WORDS - 1; i >= 0; i--)
      if (pending[i]) scan_int = i;
    scan_idx  = IDX_W'(scan_int);
    scan_push = (pending != '0) && !fifo_full;
    if (scan_push) clear_mask[scan_int] = 1'b1;
    scan_word = shadow[scan_int*WIDTH +: WIDTH];
  end

  // Coalesced changes: word already pending and not drained at this edge.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (changed[i] && pending[i] && !clear_mask[i]) drop_inc = drop_inc + 32'd1;
    drop_sum = {16'd0, drop_q} + drop_inc;
  end

  assign push_rec   = {scan_idx, scan_word, cycle_cnt};
  assign quiet_edge = primed && (changed == '0) && (pending == '0) && fifo_empty;

  // Shadow and pending mask. With en high the shadow simply tracks mem_flat:
  // on the baseline edge that is the initial copy, afterwards unchanged words
  // rewrite the same value, so no per-word enable is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      pending <= '0;
      primed  <= 1'b0;
    end else begin
      pending <= (pending & ~clear_mask) | changed;
      if (en) begin
        shadow <= mem_flat;
        primed <= 1'b1;
      end
    end
  end

  // Timestamp counter, saturating drop counter and sticky quiescence flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      drop_q    <= '0;
      quiet_cnt <= '0;
      idle_q    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (drop_sum > 32'h0000_FFFF) drop_q <= 16'hFFFF;
      else                          drop_q <= drop_sum[15:0];
      if (quiet_edge) begin
        if (quiet_cnt < Q_W'(IDLE_LIMIT))   quiet_cnt <= quiet_cnt + 1'b1;
        if (quiet_cnt == Q_W'(IDLE_LIMIT - 1)) idle_q <= 1'b1;
      end else begin
        quiet_cnt <= '0;
      end
    end
  end

  sync_fifo #(
    .DW    (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (scan_push),
    .din   (push_rec),
    .pop   (ev_valid && ev_ready),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid   = !fifo_empty;
  assign ev_index   = head_rec[EV_INDEX_LSB +: IDX_W];
  assign ev_data    = head_rec[EV_DATA_LSB +: WIDTH];
  assign ev_time    = head_rec[EV_TIME_LSB +: TS_W];
  assign drop_count = drop_q;
  assign idle_done  = idle_q;

endmodule
